// File: rtl/alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// alu_cmd_ctrl
//
// Command front-end for a registered ALU (inputs sampled on one edge, results
// valid the following cycle). Accepts one command at a time, holds the ALU
// inputs stable across the ALU latency, captures the ALU outputs and returns
// them on a valid/ready response channel. An accumulator keeps the last legal
// result so chained commands can use it as OP1.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_opcode                    0=add 1=sub 2=incr 3=decr, 4..7 illegal
//   cmd_op1/cmd_op2               operands
//   cmd_acc                       1: use accumulator instead of cmd_op1
//   alu_opcode/alu_op1/alu_op2    registered drive to the ALU
//   alu_result/alu_carry/alu_zero ALU outputs (one cycle after issue)
//   rsp_valid/rsp_ready           response handshake
//   rsp_result/rsp_carry/rsp_zero captured ALU outputs
//   rsp_err                       illegal opcode, no ALU operation performed
//   op_count                      completed non-error responses (wraps)
// -----------------------------------------------------------------------------
module alu_cmd_ctrl #(
   parameter int OPCODE_WIDTH = 2,
   parameter int DATA_WIDTH   = 31,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   // command channel
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [OPCODE_WIDTH:0] cmd_opcode,
   input  logic [DATA_WIDTH:0]   cmd_op1,
   input  logic [DATA_WIDTH:0]   cmd_op2,
   input  logic                  cmd_acc,
   // ALU interface
   output logic [OPCODE_WIDTH:0] alu_opcode,
   output logic [DATA_WIDTH:0]   alu_op1,
   output logic [DATA_WIDTH:0]   alu_op2,
   input  logic [DATA_WIDTH:0]   alu_result,
   input  logic                  alu_carry,
   input  logic                  alu_zero,
   // response channel
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH:0]   rsp_result,
   output logic                  rsp_carry,
   output logic                  rsp_zero,
   output logic                  rsp_err,
   output logic [CNT_WIDTH-1:0]  op_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_e;

   state_e                  state_q;
   logic                    cmd_ready_q;
   logic [OPCODE_WIDTH:0]   alu_opcode_q;
   logic [DATA_WIDTH:0]     alu_op1_q;
   logic [DATA_WIDTH:0]     alu_op2_q;
   logic [DATA_WIDTH:0]     acc_q;
   logic                    rsp_valid_q;
   logic [DATA_WIDTH:0]     rsp_result_q;
   logic                    rsp_carry_q;
   logic                    rsp_zero_q;
   logic                    rsp_err_q;
   logic [CNT_WIDTH-1:0]    op_count_q;

   // Legal opcodes are 0..3: every bit above bit 1 must be clear.
   logic cmd_legal;
   assign cmd_legal = ((cmd_opcode >> 2) == '0);

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         cmd_ready_q  <= 1'b1;
         alu_opcode_q <= '0;
         alu_op1_q    <= '0;
         alu_op2_q    <= '0;
         acc_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         op_count_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_ready_q <= 1'b0;
                  if (cmd_legal) begin
                     alu_opcode_q <= cmd_opcode;
                     alu_op1_q    <= cmd_acc ? acc_q : cmd_op1;
                     alu_op2_q    <= cmd_op2;
                     state_q      <= ISSUE;
                  end else begin
                     // Error response goes straight out; the ALU inputs and
                     // the accumulator keep their previous values.
                     rsp_err_q    <= 1'b1;
                     rsp_result_q <= '0;
                     rsp_carry_q  <= 1'b0;
                     rsp_zero_q   <= 1'b0;
                     rsp_valid_q  <= 1'b1;
                     state_q      <= RESP;
                  end
               end
            end

            // The ALU samples the held inputs at the end of this cycle.
            ISSUE: state_q <= CAPTURE;

            CAPTURE: begin
               rsp_result_q <= alu_result;
               rsp_carry_q  <= alu_carry;
               rsp_zero_q   <= alu_zero;
               rsp_err_q    <= 1'b0;
               rsp_valid_q  <= 1'b1;
               acc_q        <= alu_result;
               op_count_q   <= op_count_q + CNT_WIDTH'(1);
               state_q      <= RESP;
            end

            RESP: begin
               // cmd_ready rises only after the handshake edge, so a new
               // command can never be taken in the same cycle.
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_op1    = alu_op1_q;
   assign alu_op2    = alu_op2_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_carry  = rsp_carry_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;
   assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_ctrl
//
// Self-checking bench for alu_cmd_ctrl. Provides a registered ALU stub,
// drives directed scenarios followed by randomized commands, and predicts
// every response from a behavioural model (33-bit arithmetic, accumulator
// and a modulo operation counter). A small counter width makes wrap visible.
// -----------------------------------------------------------------------------
module tb_alu_cmd_ctrl;

   localparam int OW = 2;
   localparam int DW = 31;
   localparam int CW = 4;

   logic          clk;
   logic          rstn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [OW:0]   cmd_opcode;
   logic [DW:0]   cmd_op1;
   logic [DW:0]   cmd_op2;
   logic          cmd_acc;
   logic [OW:0]   alu_opcode;
   logic [DW:0]   alu_op1;
   logic [DW:0]   alu_op2;
   logic [DW:0]   alu_result;
   logic          alu_carry;
   logic          alu_zero;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW:0]   rsp_result;
   logic          rsp_carry;
   logic          rsp_zero;
   logic          rsp_err;
   logic [CW-1:0] op_count;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [31:0] m_acc;
   int          m_cnt;
   logic [2:0]  m_opc;
   logic [31:0] m_op1;
   logic [31:0] m_op2;

   alu_cmd_ctrl #(
      .OPCODE_WIDTH (OW),
      .DATA_WIDTH   (DW),
      .CNT_WIDTH    (CW)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_opcode (cmd_opcode),
      .cmd_op1    (cmd_op1),
      .cmd_op2    (cmd_op2),
      .cmd_acc    (cmd_acc),
      .alu_opcode (alu_opcode),
      .alu_op1    (alu_op1),
      .alu_op2    (alu_op2),
      .alu_result (alu_result),
      .alu_carry  (alu_carry),
      .alu_zero   (alu_zero),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_carry  (rsp_carry),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err),
      .op_count   (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic as 33-bit values: bit 32 is carry/borrow, zero covers all 33.
   function automatic logic [32:0] alu_math(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      logic [32:0] r;
      case (op)
         3'd0:    r = {1'b0, a} + {1'b0, b};
         3'd1:    r = {1'b0, a} - {1'b0, b};
         3'd2:    r = {1'b0, a} + 33'd1;
         3'd3:    r = {1'b0, a} - 33'd1;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Registered ALU stub: samples inputs on an edge, result valid next cycle.
   always @(posedge clk) begin
      logic [32:0] r;
      r = alu_math(alu_opcode, alu_op1, alu_op2);
      alu_result <= r[31:0];
      alu_carry  <= r[32];
      alu_zero   <= (r == 33'd0);
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_alu_held(input string tag);
      check({tag, "_alu_opc"}, 64'(alu_opcode), 64'(m_opc));
      check({tag, "_alu_op1"}, 64'(alu_op1), 64'(m_op1));
      check({tag, "_alu_op2"}, 64'(alu_op2), 64'(m_op2));
   endtask

   // Issue one command from IDLE, check latency and response, optionally
   // stall the response for `stall` cycles (with a stray command poke).
   task automatic do_cmd(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic use_acc,
                         input int stall, input bit poke);
      logic [31:0] op1;
      logic [32:0] full;
      logic [31:0] e_res;
      logic        e_car, e_zer, e_err;
      bit          legal;
      legal = (op < 3'd4);
      op1   = use_acc ? m_acc : a;

      check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_op1    = a;
      cmd_op2    = b;
      cmd_acc    = use_acc;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op1   = $urandom;
      rsp_ready = (stall == 0);
      check("busy_cmd_ready", 64'(cmd_ready), 64'd0);

      if (legal) begin
         m_opc = op; m_op1 = op1; m_op2 = b;
         check_alu_held("issue");
         check("lat_t1_valid", 64'(rsp_valid), 64'd0);
         @(negedge clk);
         check("lat_t2_valid", 64'(rsp_valid), 64'd0);
         @(negedge clk);
         full  = alu_math(op, op1, b);
         e_res = full[31:0];
         e_car = full[32];
         e_zer = (full == 33'd0);
         e_err = 1'b0;
         m_acc = full[31:0];
         m_cnt = (m_cnt + 1) % (1 << CW);
      end else begin
         e_res = '0; e_car = 1'b0; e_zer = 1'b0; e_err = 1'b1;
         check_alu_held("illegal");
      end

      check("rsp_valid", 64'(rsp_valid), 64'd1);
      check("rsp_result", 64'(rsp_result), 64'(e_res));
      check("rsp_carry", 64'(rsp_carry), 64'(e_car));
      check("rsp_zero", 64'(rsp_zero), 64'(e_zer));
      check("rsp_err", 64'(rsp_err), 64'(e_err));
      check("op_count", 64'(op_count), 64'(m_cnt));

      for (int i = 0; i < stall; i++) begin
         if (poke && i == 0) begin
            cmd_valid  = 1'b1;
            cmd_opcode = 3'($urandom_range(0, 3));
            cmd_op1    = $urandom;
            cmd_op2    = $urandom;
            cmd_acc    = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         cmd_valid = 1'b0;
         check("stall_valid", 64'(rsp_valid), 64'd1);
         check("stall_result", 64'(rsp_result), 64'(e_res));
         check("stall_flags", 64'({rsp_carry, rsp_zero, rsp_err}),
               64'({e_car, e_zer, e_err}));
         check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
         check_alu_held("stall");
      end

      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_valid", 64'(rsp_valid), 64'd0);
      check("post_cmd_ready", 64'(cmd_ready), 64'd1);
      check("post_count", 64'(op_count), 64'(m_cnt));
      check_alu_held("post");
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      check({tag, "_rsp_fields"},
            64'({rsp_result, rsp_carry, rsp_zero, rsp_err}), 64'd0);
      check({tag, "_alu"}, 64'({alu_opcode, alu_op1}), 64'd0);
      check({tag, "_alu_op2"}, 64'(alu_op2), 64'd0);
      check({tag, "_count"}, 64'(op_count), 64'd0);
   endtask

   task automatic model_reset();
      m_acc = '0; m_cnt = 0; m_opc = '0; m_op1 = '0; m_op2 = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pick [4];
      rstn = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_op1 = '0;
      cmd_op2 = '0; cmd_acc = 1'b0; rsp_ready = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rstn = 1'b1;
      @(negedge clk);

      // Directed scenarios
      do_cmd(3'd0, 32'h5, 32'h3, 1'b0, 0, 1'b0);
      do_cmd(3'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 0, 1'b0);
      do_cmd(3'd1, 32'h10, 32'h10, 1'b0, 0, 1'b0);
      do_cmd(3'd2, 32'h7, 32'h0, 1'b0, 0, 1'b0);
      do_cmd(3'd2, 32'hDEAD, 32'h0, 1'b1, 0, 1'b0);
      do_cmd(3'd3, 32'h1234, 32'h0, 1'b1, 0, 1'b0);
      do_cmd(3'd5, 32'h99, 32'h77, 1'b0, 0, 1'b0);
      do_cmd(3'd2, 32'h0, 32'h0, 1'b1, 0, 1'b0);   // acc untouched by error
      do_cmd(3'd0, 32'hA, 32'hB, 1'b0, 5, 1'b1);   // backpressure + poke
      do_cmd(3'd7, 32'h1, 32'h1, 1'b0, 3, 1'b1);

      // Reset during CAPTURE: nothing may come out
      cmd_valid = 1'b1; cmd_opcode = 3'd0; cmd_op1 = 32'h40;
      cmd_op2 = 32'h2; cmd_acc = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      model_reset();
      check_reset_values("midop");
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("midop_no_rsp", 64'(rsp_valid), 64'd0);
      end
      do_cmd(3'd0, 32'h1, 32'h1, 1'b0, 0, 1'b0);

      // Randomized commands (counter wraps several times)
      pick[0] = 32'h0; pick[1] = 32'hFFFF_FFFF; pick[2] = 32'h1;
      pick[3] = 32'h8000_0000;
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a, b;
         a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)]
                                         : $urandom;
         b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)]
                                         : $urandom;
         do_cmd(3'($urandom_range(0, 7)), a, b, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
